mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified backing-memory port between the instruction-fetch side (Icache/mcache
//  miss path, read-only) and the data side (Mbox load/store). Grants one requester at a
//  time, drives the port with a req/ack handshake, returns data and stall signals to the
//  pipeline. Data side has priority; a streak limit prevents fetch starvation; a timeout
//  converts a hung memory into a bus error.
// PARAMETERS
//  ADDR_W          64  address width, both requesters and memory port
//  DATA_W          64  memory port data width; fetch data is DATA_W/2 = 32
//  TIMEOUT_CYCLES  64  cycles in BUSY without mem_ack before bus error; 0 = disabled
//  D_STREAK_MAX     4  consecutive D grants allowed while i_req pending before forcing I
// PORTS
//  clk         in   1       clock; all state on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  i_req       in   1       fetch request; held with i_addr until i_done
//  i_addr      in   ADDR_W  fetch byte address; [1:0] ignored
//  i_rdata     out  32      fetch word; valid while i_done=1
//  i_done      out  1       one-cycle completion pulse to fetch side
//  i_stall     out  1       i_req & ~i_done (combinational)
//  d_req       in   1       data request; held with d_we/d_addr/d_wdata until d_done
//  d_we        in   1       1 = store, 0 = load
//  d_addr      in   ADDR_W  data byte address; [2:0] ignored
//  d_wdata     in   DATA_W  store data
//  d_rdata     out  DATA_W  load data; valid while d_done=1
//  d_done      out  1       one-cycle completion pulse to data side
//  d_stall     out  1       d_req & ~d_done (combinational)
//  mem_req     out  1       registered; high for whole transaction until ack
//  mem_we      out  1       registered copy of latched d_we (0 for fetch)
//  mem_addr    out  ADDR_W  {latched addr[ADDR_W-1:3], 3'b0}
//  mem_wdata   out  DATA_W  latched d_wdata (0 for fetch)
//  mem_rdata   in   DATA_W  read data, valid in mem_ack cycle
//  mem_ack     in   1       one-cycle completion from memory
//  bus_err     out  1       one-cycle pulse coincident with done on timeout
//  owner       out  2       00 none, 01 fetch, 10 data (debug)
// BEHAVIOUR
//  Reset (async): state IDLE, every output 0, streak and timeout counters 0; mem_req drops
//   immediately; a mem_ack arriving after reset is ignored.
//  States: IDLE -> BUSY_I | BUSY_D -> RESP -> IDLE.
//  IDLE: if d_req & i_req: grant D unless streak==D_STREAK_MAX, then grant I. Else grant the
//   single requester. Grant latches addr/we/wdata; next cycle mem_req=1, owner set.
//  Streak: D grant with i_req high -> streak+1 (saturating); any I grant or D grant with
//   i_req low -> streak=0.
//  BUSY_x: mem_req/mem_addr/mem_we/mem_wdata held stable. On mem_ack: capture mem_rdata
//   (fetch: addr[2]=0 -> [31:0], addr[2]=1 -> [63:32]), go RESP, mem_req=0 next cycle.
//  Timeout: counter starts at 0 on entry to BUSY, +1 per cycle; when it reaches
//   TIMEOUT_CYCLES-1 without ack -> RESP with rdata=0 and bus_err=1. Ack in the expiry
//   cycle wins (no error).
//  RESP: exactly one cycle; owner's done=1 (plus bus_err if timed out); new reqs ignored
//   so requester can drop req; then IDLE, owner=00.
//  Latency: grant edge -> mem_req next cycle; ack cycle -> done next cycle. Min
//   back-to-back transaction period = 3 + memory latency cycles.
//  mem_ack in IDLE or RESP: ignored. Requester dropping req mid-transaction: transaction
//   still completes, done still pulses (harmless).
//  Outputs i_rdata/d_rdata hold last value outside done; only done qualifies them.
// TESTING
//  1 Single fetch i_addr=0x1004, ack after 2 cycles with mem_rdata=0xAAAA_BBBB_CCCC_DDDD ->
//    mem_addr=0x1000, i_rdata=0xAAAABBBB with i_done one cycle, i_stall low after.
//  2 Store d_addr=0x2008, d_wdata=0x1234 -> mem_we=1, mem_addr=0x2008, mem_wdata=0x1234, d_done.
//  3 i_req and d_req held continuously, ack 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I.
//  4 TIMEOUT_CYCLES=8, never ack -> d_done and bus_err same cycle, 8 cycles after mem_req
//    rose, d_rdata=0; next request serviced normally.
//  5 reset_n low mid-BUSY_D -> mem_req, owner, stalls' done terms 0 asynchronously; late
//    mem_ack ignored; no done pulse.
//  6 Ack arriving exactly at timeout expiry -> done with real data, bus_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one backing-memory port between the instruction-fetch side (read-only)
//   and the data side (load/store). One transaction at a time over a req/ack
//   handshake. Data side wins ties, but a streak limit forces a fetch grant after
//   D_STREAK_MAX consecutive data grants that each found a fetch waiting. A
//   transaction that sees no mem_ack for TIMEOUT_CYCLES cycles completes with
//   zero data and a bus_err pulse (TIMEOUT_CYCLES = 0 disables the timeout).
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   i_req/i_addr                  fetch request (held until i_done)
//   i_rdata/i_done/i_stall        fetch word, completion pulse, stall
//   d_req/d_we/d_addr/d_wdata     data request (held until d_done)
//   d_rdata/d_done/d_stall        load data, completion pulse, stall
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     registered memory request, stable through BUSY
//   mem_rdata/mem_ack             memory read data, one-cycle completion
//   bus_err                       timeout pulse, coincident with done
//   owner                         debug: 00 none, 01 fetch, 10 data
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int D_STREAK_MAX   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W/2-1:0] i_rdata,
  output logic                i_done,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                bus_err,
  output logic [1:0]          owner
);

  localparam int FW = DATA_W / 2;
  localparam int SW = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [SW-1:0] STREAK_LIM = SW'(D_STREAK_MAX);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t        state, state_n;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic          fetch_hi;
  logic          grant_i, grant_d, take_ack, expire;

  // Byte-offset bits below the word/doubleword boundary are not used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    take_ack = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless fetch is waiting and the data streak is exhausted.
        if (d_req && !(i_req && streak == STREAK_LIM)) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // Ack in the expiry cycle takes precedence over the timeout.
        if (mem_ack) begin
          take_ack = 1'b1;
          state_n  = RESP;
        end else if (TO_EN && tcnt == TO_LAST) begin
          expire  = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak    <= '0;
      tcnt      <= '0;
      fetch_hi  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 2'b00;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      bus_err <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= {d_addr[ADDR_W-1:3], 3'b000};
        mem_wdata <= d_wdata;
        owner     <= 2'b10;
        tcnt      <= '0;
        if (i_req) streak <= (streak == STREAK_LIM) ? streak : streak + 1'b1;
        else       streak <= '0;
      end

      if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {i_addr[ADDR_W-1:3], 3'b000};
        mem_wdata <= '0;
        fetch_hi  <= i_addr[2];
        owner     <= 2'b01;
        tcnt      <= '0;
        streak    <= '0;
      end

      if ((state == BUSY_I || state == BUSY_D) && !take_ack && !expire)
        tcnt <= tcnt + 1'b1;

      if (take_ack || expire) begin
        mem_req <= 1'b0;
        bus_err <= expire;
        if (state == BUSY_I) begin
          i_done  <= 1'b1;
          i_rdata <= expire ? '0 : (fetch_hi ? mem_rdata[DATA_W-1:FW] : mem_rdata[FW-1:0]);
        end else begin
          d_done  <= 1'b1;
          d_rdata <= expire ? '0 : mem_rdata;
        end
      end

      if (state == RESP) owner <= 2'b00;
    end
  end

endmodule
